pico_trace_capture: RTL and testbench
=====================================

# pico_trace_capture

Parametrised, synthesisable trace-capture unit that watches the picoMIPS `display` bus on-chip. It waits for a masked trigger pattern, then records timestamped samples into an internal buffer, either every cycle or only when the value changes. After capture it holds the buffer for random-access readback. It sits beside `picoMIPS`, driven by the same `clk`, and replaces waveform-dump-only observation on hardware builds.

## Interface
- `n`, default 8: width of the observed bus.
- `DEPTH`, default 16: buffer entries, ≥2.
- `TS_W`, default 8: timestamp width.
- `clk` in 1: the only clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk`.
- `display` in n: observed bus.
- `arm` in 1: one-cycle pulse that starts a capture session.
- `stop` in 1: aborts or ends the session.
- `mode` in 1: 0 = change-only, 1 = every cycle.
- `trig_value` in n: trigger pattern.
- `trig_mask` in n: trigger mask. 1 = bit compared.
- `rd_en` in 1: readback request.
- `rd_addr` in $clog2(DEPTH): readback entry.
- `rd_data` out TS_W+n: {timestamp, sample}.
- `rd_valid` out 1: read response strobe.
- `count` out $clog2(DEPTH+1): number of entries written.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: high in DONE.

## Operation
- **States:** IDLE, ARMED, CAPTURE, DONE.
- **IDLE**
  - `arm` → ARMED, `count`←0.
  - `stop` is ignored.
- **ARMED**
  - Trigger condition: `(display & trig_mask) == (trig_value & trig_mask)`.
  - On trigger → CAPTURE. The same cycle writes entry 0 = {0, display}, `count`←1, timestamp counter←1, last←display.
  - `trig_mask`=0 triggers on the first ARMED cycle.
  - `stop` → IDLE. `stop` beats a simultaneous trigger, so nothing is written.
- **CAPTURE**
  - Write enable: mode 1 writes every cycle. Mode 0 writes only when `display != last`.
  - Each write stores {ts, display} at address `count`, then `count`++ and last←display.
  - The timestamp counter increments every CAPTURE cycle and saturates at 2^TS_W−1; it never wraps.
  - When `count` reaches DEPTH → DONE. Later `display` activity is ignored.
  - `stop` → DONE. A write due in the same cycle still happens.
  - `arm` is ignored.
- **DONE**
  - Buffer and `count` are frozen.
  - `arm` → ARMED, `count`←0. Old contents become invisible.
- **Readback** (legal in any state)
  - `rd_en` at cycle t gives `rd_valid`=1 at t+1.
  - `rd_data` = stored entry if `rd_addr < count`, else 0.
  - `rd_valid`=0 whenever `rd_en` was 0 the previous cycle.
- **Reset**
  - `reset`=0 at any edge, including mid-capture, forces IDLE, `count`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, timestamp=0.
  - RAM contents are not cleared. Because `count`=0, all reads return 0.

## Timing
- Arm to ARMED: 1 cycle.
- Trigger-cycle sample: written in that same cycle. `busy` stays 1 and `count`=1 from the next cycle.
- `done` rises 1 cycle after the final write or after `stop` is sampled.
- Read latency: exactly 1 cycle, fully pipelined, with one read per cycle sustained.
- Same-address read and write in the same cycle returns the previous contents. In practice this only occurs with `rd_addr` ≥ old `count`, so the result is 0.
- All outputs are registered.

## Structure
- Package `pico_trace_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} trace_state_t`
  - constants `MODE_CHANGE`=0 and `MODE_EVERY`=1.
- Sub-module `pico_trace_ram`: simple dual-port synchronous RAM, DEPTH × (TS_W+n). One write port, one registered read port, no reset on the storage array.
- The top level holds the FSM, `count`, the timestamp counter, the `last` register, the trigger compare, and the read-range gating.

## Test plan
- **Reset:** n=8, DEPTH=4, TS_W=8. Hold `reset`=0 for 2 cycles with `arm`=1 → IDLE, `count`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0.
- **Masked trigger, change-only:** mask=F0, value=30, `mode`=0. `display` = 2A, 35, 35, 36, 36, 07, 08 → entries {00,35}, {02,36}, {04,07}, {05,08}. `count`=4. `done`=1 one cycle after the 08 write.
- **Every-cycle, full buffer:** `mode`=1, DEPTH=4. Trigger on 10, then `display` increments every cycle → entries ts 0..3, samples 10..13, DONE. Later changes leave `count`=4.
- **Stop handling:**
  - `stop` in the same cycle as a trigger while ARMED → IDLE, `count`=0.
  - `stop` in CAPTURE after 2 writes → DONE, `count`=2. Reading addr 3 gives `rd_valid`=1, `rd_data`=0.
- **Timestamp saturation:** TS_W=2, `mode`=0. Trigger, then the first change 5 cycles later → entry 1 ts=3, not 1.
- **Reset mid-capture:** after 3 writes, pulse `reset`=0 → IDLE. Reading addr 0 returns 0. Re-arm and capture again → fresh entries starting at ts 0.

Source files
------------

// File: rtl/pico_trace_pkg.sv
// rtl/pico_trace_pkg.sv - shared types and constants for the trace capture unit
package pico_trace_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} trace_state_t;

    localparam logic MODE_CHANGE = 1'b0;
    localparam logic MODE_EVERY  = 1'b1;

endpackage

// File: rtl/pico_trace_ram.sv
// rtl/pico_trace_ram.sv - simple dual-port sample buffer with registered read port
module pico_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;

    // Read samples the array before this edge's write lands: same-address returns old data.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pico_trace_capture.sv
// rtl/pico_trace_capture.sv - triggered, timestamped capture of the display bus with readback
module pico_trace_capture
    import pico_trace_pkg::*;
#(
    parameter int n     = 8,
    parameter int DEPTH = 16,
    parameter int TS_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [n-1:0]               display,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       mode,
    input  logic [n-1:0]               trig_value,
    input  logic [n-1:0]               trig_mask,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [TS_W+n-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = TS_W + n;

    trace_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [n-1:0]  last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          trig_hit;
    logic          rd_in_range;

    assign trig_hit    = ((display ^ trig_value) & trig_mask) == '0;
    assign rd_in_range = CW'(rd_addr) < count_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ts_d       = ts_q;
        last_d     = last_q;
        we         = 1'b0;
        waddr      = count_q[AW-1:0];
        wdata      = {ts_q, display};
        rd_valid_d = rd_en;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            ARMED: begin
                // stop wins over a coincident trigger so an aborted session leaves no entries
                if (stop) begin
                    state_d = IDLE;
                end else if (trig_hit) begin
                    state_d = CAPTURE;
                    we      = 1'b1;
                    waddr   = '0;
                    wdata   = {{TS_W{1'b0}}, display};
                    count_d = CW'(1);
                    ts_d    = TS_W'(1);
                    last_d  = display;
                end
            end
            CAPTURE: begin
                if (ts_q != '1) begin
                    ts_d = ts_q + 1'b1;
                end
                if (mode == MODE_EVERY || display != last_q) begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                    last_d  = display;
                end
                if (count_d == CW'(DEPTH) || stop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (arm) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ts_q       <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Out-of-range reads never enable the RAM read, so its output register yields zero.
    pico_trace_ram #(
        .DEPTH (DEPTH),
        .W     (DW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en && rd_in_range),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pico_trace_capture.sv
// tb/tb_pico_trace_capture.sv - randomized and directed self-checking bench for pico_trace_capture
module tb_pico_trace_capture;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, arm, stop, mode, rd_en;
    logic [7:0]  display, trig_value, trig_mask;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [9:0]  rd_data_s;
    logic        rd_valid, rd_valid_s, busy, busy_s, done, done_s;
    logic [2:0]  count, count_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] stim_d [64];
    logic       stim_s [64];
    int         stim_len;

    int         m_ts  [DEPTH];
    logic [7:0] m_val [DEPTH];
    int         m_cnt, m_t0;
    bit         m_trig, m_end, m_abort;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    pico_trace_capture #(.n(8), .DEPTH(DEPTH), .TS_W(8)) dut (
        .clk(clk), .reset(reset), .display(display), .arm(arm), .stop(stop), .mode(mode),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .busy(busy), .done(done)
    );

    pico_trace_capture #(.n(8), .DEPTH(DEPTH), .TS_W(2)) dut_s (
        .clk(clk), .reset(reset), .display(display), .arm(arm), .stop(stop), .mode(mode),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .count(count_s), .busy(busy_s), .done(done_s)
    );

    task step;
        @(posedge clk);
        #1;
    endtask

    task model_arm;
        m_cnt = 0; m_trig = 0; m_end = 0; m_abort = 0;
    endtask

    // Behavioural capture rules: cycle i is the i-th cycle after arming.
    task model_cycle(input int i, input logic [7:0] d, input logic s);
        if (m_end || m_abort) return;
        if (!m_trig) begin
            if (s) m_abort = 1;
            else if ((d & trig_mask) == (trig_value & trig_mask)) begin
                m_trig = 1; m_t0 = i; m_ts[0] = 0; m_val[0] = d; m_cnt = 1; m_last = d;
            end
        end else begin
            if (mode || d != m_last) begin
                m_ts[m_cnt] = i - m_t0; m_val[m_cnt] = d; m_cnt++; m_last = d;
            end
            if (m_cnt == DEPTH || s) m_end = 1;
        end
    endtask

    task check_status(input string tag);
        logic [4:0] exp_st;
        exp_st = {3'(m_cnt), !(m_end || m_abort), m_end};
        checks++;
        if ({count, busy, done} !== exp_st) begin
            errors++;
            $display("FAIL %s status8: got count=%0d busy=%b done=%b want count=%0d busy=%b done=%b",
                     tag, count, busy, done, exp_st[4:2], exp_st[1], exp_st[0]);
        end
        checks++;
        if ({count_s, busy_s, done_s} !== exp_st) begin
            errors++;
            $display("FAIL %s status2: got count=%0d busy=%b done=%b want count=%0d busy=%b done=%b",
                     tag, count_s, busy_s, done_s, exp_st[4:2], exp_st[1], exp_st[0]);
        end
    endtask

    task readback(input string tag);
        logic [15:0] e8;
        logic [9:0]  e2;
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_addr = 2'(a);
            step;
            e8 = '0; e2 = '0;
            if (a < m_cnt) begin
                e8 = {8'((m_ts[a] > 255) ? 255 : m_ts[a]), m_val[a]};
                e2 = {2'((m_ts[a] > 3) ? 3 : m_ts[a]), m_val[a]};
            end
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e8) begin
                errors++;
                $display("FAIL %s read8[%0d]: got valid=%b data=%h want valid=1 data=%h", tag, a, rd_valid, rd_data, e8);
            end
            checks++;
            if (rd_valid_s !== 1'b1 || rd_data_s !== e2) begin
                errors++;
                $display("FAIL %s read2[%0d]: got valid=%b data=%h want valid=1 data=%h", tag, a, rd_valid_s, rd_data_s, e2);
            end
        end
        rd_en = 1'b0;
        step;
        checks++;
        if ({rd_valid, rd_valid_s} !== 2'b00) begin
            errors++;
            $display("FAIL %s rd_valid_idle: got %b%b want 00", tag, rd_valid, rd_valid_s);
        end
    endtask

    task run_scenario(input string tag, input logic m, input logic [7:0] mask, input logic [7:0] value);
        mode = m; trig_mask = mask; trig_value = value;
        arm = 1'b1;
        step;
        arm = 1'b0;
        model_arm;
        check_status({tag, " armed"});
        for (int i = 0; i < stim_len; i++) begin
            display = stim_d[i]; stop = stim_s[i];
            step;
            model_cycle(i, stim_d[i], stim_s[i]);
            check_status(tag);
        end
        stop = 1'b0;
        readback(tag);
    endtask

    task load_stim(input logic [63:0] dv, input logic [7:0] sv, input int len);
        stim_len = len;
        for (int i = 0; i < len; i++) begin
            stim_d[i] = dv[8*(len-1-i) +: 8];
            stim_s[i] = sv[len-1-i];
        end
    endtask

    task test_reset;
        reset = 1'b0; arm = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
        step;
        step;
        checks++;
        if ({count, busy, done, rd_valid, rd_data} !== 22'd0) begin
            errors++;
            $display("FAIL reset8: got count=%0d busy=%b done=%b valid=%b data=%h want all 0",
                     count, busy, done, rd_valid, rd_data);
        end
        checks++;
        if ({count_s, busy_s, done_s, rd_valid_s, rd_data_s} !== 16'd0) begin
            errors++;
            $display("FAIL reset2: got count=%0d busy=%b done=%b valid=%b data=%h want all 0",
                     count_s, busy_s, done_s, rd_valid_s, rd_data_s);
        end
        reset = 1'b1; arm = 1'b0; rd_en = 1'b0;
        step;
    endtask

    task test_change_only;
        load_stim(64'h00_2A_35_35_36_36_07_08, 8'h00, 7);
        run_scenario("change_only", 1'b0, 8'hF0, 8'h30);
    endtask

    task test_every_cycle;
        load_stim(64'h0E_0F_10_11_12_13_14_15, 8'h00, 8);
        run_scenario("every_cycle", 1'b1, 8'hFF, 8'h10);
    endtask

    task test_stop;
        load_stim(64'h21_22_22_22, 8'b0100, 4);
        run_scenario("stop_at_trigger", 1'b1, 8'hFF, 8'h22);
        load_stim(64'h44_45_45_46, 8'b0010, 4);
        run_scenario("stop_in_capture", 1'b0, 8'hFF, 8'h44);
    endtask

    task test_ts_saturation;
        load_stim(64'h40_40_40_40_40_41_41, 8'b0000001, 7);
        run_scenario("ts_saturation", 1'b0, 8'h00, 8'h00);
    endtask

    task test_reset_mid;
        mode = 1'b1; trig_mask = 8'h00; trig_value = 8'h00;
        arm = 1'b1;
        step;
        arm = 1'b0;
        model_arm;
        for (int i = 0; i < 3; i++) begin
            display = 8'h50 + 8'(i);
            step;
            model_cycle(i, display, 1'b0);
        end
        check_status("pre_reset");
        reset = 1'b0;
        step;
        reset = 1'b1;
        model_arm;
        m_abort = 1;
        check_status("reset_mid");
        rd_en = 1'b1; rd_addr = 2'd0;
        step;
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0 || rd_valid_s !== 1'b1 || rd_data_s !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid_read: got %b/%h %b/%h want 1/0000 1/000", rd_valid, rd_data, rd_valid_s, rd_data_s);
        end
        load_stim(64'h60_60_61_62_63, 8'h00, 5);
        run_scenario("rearm_after_reset", 1'b1, 8'hFF, 8'h60);
    endtask

    task test_random;
        logic [7:0] mask, value, prev;
        logic       m;
        for (int t = 0; t < 10; t++) begin
            m     = 1'($urandom_range(0, 1));
            mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            value = 8'($urandom);
            stim_len = $urandom_range(4, 20);
            prev = 8'($urandom);
            for (int i = 0; i < stim_len; i++) begin
                case ($urandom_range(0, 3))
                    0:       stim_d[i] = value;
                    1:       stim_d[i] = value ^ 8'h80;
                    2:       stim_d[i] = 8'($urandom);
                    default: stim_d[i] = prev;
                endcase
                prev = stim_d[i];
                stim_s[i] = (i == stim_len - 1) || ($urandom_range(0, 9) == 0);
            end
            run_scenario($sformatf("random%0d", t), m, mask, value);
        end
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; stop = 1'b0; mode = 1'b0; rd_en = 1'b0; rd_addr = 2'd0;
        display = 8'h00; trig_value = 8'h00; trig_mask = 8'h00;
        test_reset;
        test_change_only;
        test_every_cycle;
        test_stop;
        test_ts_saturation;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
